// File: rtl/host_cmd_parser.sv
// host_cmd_parser: byte-level parser for host command frames (HDR, CMD, PARAM, SUM)
// on the camera-control UART receive path. Validated frames update the zoom/focus/
// iris/preset/defog command levels and fire a stretched flag_data_recieve strobe;
// corrupt, unknown or timed-out frames pulse frame_err.
// Ports:
//   clk, rst (async, active-low)
//   rx_data[7:0], rx_valid          : received byte and its one-cycle strobe
//   flag_data_recieve               : new-command strobe, PULSE_LEN cycles high
//   video_switch_enable, big_to_small_flag           : zoom
//   foc_enable, foc_dir, foc_step[3:0]               : focus
//   Iris_enable, Iris_dir, Iris_step[4:0]            : iris
//   pre_view_enable, pre_view[7:0]                   : preset view
//   touwu                                            : defog state
//   frame_err                       : one-cycle pulse on a discarded frame
module host_cmd_parser #(
  parameter logic [7:0]  HDR       = 8'hAA,
  parameter logic [15:0] TIMEOUT   = 16'd50000,
  parameter logic [7:0]  PULSE_LEN = 8'd32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       flag_data_recieve,
  output logic       video_switch_enable,
  output logic       big_to_small_flag,
  output logic       foc_enable,
  output logic       foc_dir,
  output logic [3:0] foc_step,
  output logic       Iris_enable,
  output logic       Iris_dir,
  output logic [4:0] Iris_step,
  output logic       pre_view_enable,
  output logic [7:0] pre_view,
  output logic       touwu,
  output logic       frame_err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TMO_W  = 16;

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    GET_CMD   = 2'd1,
    GET_PARAM = 2'd2,
    GET_SUM   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] cmd_q, cmd_d;
  logic [BYTE_W-1:0] param_q, param_d;
  logic [BYTE_W-1:0] sum_q, sum_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [BYTE_W-1:0] pulse_q;
  logic              commit_c;
  logic              err_c;
  logic              known_c;

  // Parser state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      cmd_q   <= '0;
      param_q <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      param_q <= param_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state: byte sequencing, running XOR, inter-byte timeout
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    param_d  = param_q;
    sum_d    = sum_q;
    tmo_d    = tmo_q;
    commit_c = 1'b0;
    err_c    = 1'b0;
    known_c  = (cmd_q >= 8'd1) && (cmd_q <= 8'd5);

    if (rx_valid) begin
      // A byte always beats a timeout on the same cycle
      tmo_d = '0;
      case (state_q)
        HUNT: begin
          if (rx_data == HDR) begin
            state_d = GET_CMD;
            sum_d   = HDR;
          end
        end
        GET_CMD: begin
          cmd_d   = rx_data;
          sum_d   = sum_q ^ rx_data;
          state_d = GET_PARAM;
        end
        GET_PARAM: begin
          param_d = rx_data;
          sum_d   = sum_q ^ rx_data;
          state_d = GET_SUM;
        end
        GET_SUM: begin
          if ((rx_data == sum_q) && known_c) begin
            commit_c = 1'b1;
          end else begin
            err_c = 1'b1;
          end
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end else if (state_q != HUNT) begin
      if (tmo_q == TIMEOUT - 16'd1) begin
        tmo_d   = '0;
        state_d = HUNT;
        err_c   = 1'b1;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end
  end

  // Command outputs, pulse stretcher and error strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_data_recieve   <= 1'b0;
      pulse_q             <= '0;
      video_switch_enable <= 1'b0;
      big_to_small_flag   <= 1'b0;
      foc_enable          <= 1'b0;
      foc_dir             <= 1'b0;
      foc_step            <= '0;
      Iris_enable         <= 1'b0;
      Iris_dir            <= 1'b0;
      Iris_step           <= '0;
      pre_view_enable     <= 1'b0;
      pre_view            <= '0;
      touwu               <= 1'b0;
      frame_err           <= 1'b0;
    end else begin
      frame_err <= err_c;
      if (commit_c) begin
        // Flag stays high this edge plus PULSE_LEN-1 further edges
        flag_data_recieve   <= 1'b1;
        pulse_q             <= PULSE_LEN - 8'd1;
        video_switch_enable <= 1'b0;
        foc_enable          <= 1'b0;
        Iris_enable         <= 1'b0;
        pre_view_enable     <= 1'b0;
        case (cmd_q)
          8'd1: begin
            video_switch_enable <= 1'b1;
            big_to_small_flag   <= param_q[0];
          end
          8'd2: begin
            foc_enable <= 1'b1;
            foc_dir    <= param_q[7];
            foc_step   <= param_q[3:0];
          end
          8'd3: begin
            pre_view_enable <= 1'b1;
            pre_view        <= param_q;
          end
          8'd4: begin
            Iris_enable <= 1'b1;
            Iris_dir    <= param_q[7];
            Iris_step   <= param_q[4:0];
          end
          default: touwu <= param_q[0];
        endcase
      end else if (pulse_q != '0) begin
        pulse_q <= pulse_q - 8'd1;
      end else begin
        flag_data_recieve <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_host_cmd_parser.sv
// Self-checking bench for host_cmd_parser: frame-level reference model compared
// against every output on every falling edge, plus directed literal checks.
module tb_host_cmd_parser;

  localparam logic [7:0] HDR       = 8'hAA;
  localparam int         TIMEOUT   = 50000;
  localparam int         PULSE_LEN = 32;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       flag_data_recieve, video_switch_enable, big_to_small_flag;
  logic       foc_enable, foc_dir, Iris_enable, Iris_dir, pre_view_enable;
  logic       touwu, frame_err;
  logic [3:0] foc_step;
  logic [4:0] Iris_step;
  logic [7:0] pre_view;

  host_cmd_parser dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_data             (rx_data),
    .rx_valid            (rx_valid),
    .flag_data_recieve   (flag_data_recieve),
    .video_switch_enable (video_switch_enable),
    .big_to_small_flag   (big_to_small_flag),
    .foc_enable          (foc_enable),
    .foc_dir             (foc_dir),
    .foc_step            (foc_step),
    .Iris_enable         (Iris_enable),
    .Iris_dir            (Iris_dir),
    .Iris_step           (Iris_step),
    .pre_view_enable     (pre_view_enable),
    .pre_view            (pre_view),
    .touwu               (touwu),
    .frame_err           (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bytes of the frame in progress, idle cycles, expected outputs
  logic [7:0] frm[$];
  int         idle;
  int         rem;
  logic       m_vse, m_bts, m_fen, m_fdir, m_ien, m_idir, m_pen, m_touwu, m_err;
  logic [3:0] m_fstep;
  logic [4:0] m_istep;
  logic [7:0] m_pview;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      frm.delete();
      idle = 0; rem = 0;
      m_vse = 0; m_bts = 0; m_fen = 0; m_fdir = 0; m_ien = 0; m_idir = 0;
      m_pen = 0; m_touwu = 0; m_err = 0; m_fstep = 0; m_istep = 0; m_pview = 0;
    end else begin
      logic commit;
      logic [7:0] c, p;
      commit = 0;
      m_err  = 0;
      if (rx_valid) begin
        idle = 0;
        if (frm.size() == 0) begin
          if (rx_data == HDR) frm.push_back(rx_data);
        end else begin
          frm.push_back(rx_data);
          if (frm.size() == 4) begin
            c = frm[1];
            p = frm[2];
            if (((frm[0] ^ frm[1] ^ frm[2] ^ frm[3]) == 8'h00) && c >= 1 && c <= 5) begin
              commit = 1;
              m_vse = (c == 1); m_fen = (c == 2); m_pen = (c == 3); m_ien = (c == 4);
              if (c == 1) m_bts = p[0];
              if (c == 2) begin m_fdir = p[7]; m_fstep = p[3:0]; end
              if (c == 3) m_pview = p;
              if (c == 4) begin m_idir = p[7]; m_istep = p[4:0]; end
              if (c == 5) m_touwu = p[0];
            end else begin
              m_err = 1;
            end
            frm.delete();
          end
        end
      end else if (frm.size() != 0) begin
        idle++;
        if (idle == TIMEOUT) begin
          m_err = 1;
          frm.delete();
          idle = 0;
        end
      end
      if (commit) rem = PULSE_LEN;
      else if (rem > 0) rem--;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("flag",     32'(flag_data_recieve),   32'(rem > 0));
    chk("zoom_en",  32'(video_switch_enable), 32'(m_vse));
    chk("zoom_dir", 32'(big_to_small_flag),   32'(m_bts));
    chk("foc_en",   32'(foc_enable),          32'(m_fen));
    chk("foc_dir",  32'(foc_dir),             32'(m_fdir));
    chk("foc_step", 32'(foc_step),            32'(m_fstep));
    chk("iris_en",  32'(Iris_enable),         32'(m_ien));
    chk("iris_dir", 32'(Iris_dir),            32'(m_idir));
    chk("iris_stp", 32'(Iris_step),           32'(m_istep));
    chk("pre_en",   32'(pre_view_enable),     32'(m_pen));
    chk("pre_view", 32'(pre_view),            32'(m_pview));
    chk("touwu",    32'(touwu),               32'(m_touwu));
    chk("frm_err",  32'(frame_err),           32'(m_err));
  end

  // Drive one cycle of input, sampled at the following rising edge
  task automatic put(input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    rx_valid = v;
    rx_data  = d;
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    put(1'b1, b0); put(1'b1, b1); put(1'b1, b2); put(1'b1, b3);
  endtask

  // Counts flag high negedges starting from the current (already high) one
  task automatic flag_len(input string nm);
    int cnt;
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (flag_data_recieve) cnt++;
      else break;
    end
    chk(nm, 32'(cnt), 32'd32);
  endtask

  initial begin
    int k;
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_flag", 32'(flag_data_recieve), 32'd0);
    chk("rst_pview", 32'(pre_view), 32'd0);
    @(posedge clk); #3 rst = 1'b1;
    repeat (3) put(1'b0, 8'h00);

    // Zoom
    frame(8'hAA, 8'h01, 8'h01, 8'hAA); put(1'b0, 8'h00);
    @(negedge clk);
    chk("zoom_en_lit",  32'(video_switch_enable), 32'd1);
    chk("zoom_dir_lit", 32'(big_to_small_flag),   32'd1);
    chk("zoom_foc_lit", 32'(foc_enable),          32'd0);
    chk("zoom_flag_lit", 32'(flag_data_recieve),  32'd1);
    flag_len("zoom_pulse_len");

    // Focus then preset, back-to-back
    frame(8'hAA, 8'h02, 8'h85, 8'h2D);
    put(1'b1, 8'hAA);
    @(negedge clk);
    chk("foc_en_lit",   32'(foc_enable), 32'd1);
    chk("foc_dir_lit",  32'(foc_dir),    32'd1);
    chk("foc_step_lit", 32'(foc_step),   32'd5);
    put(1'b1, 8'h03); put(1'b1, 8'h2F); put(1'b1, 8'h86); put(1'b0, 8'h00);
    @(negedge clk);
    chk("pre_en_lit",    32'(pre_view_enable), 32'd1);
    chk("pre_view_lit",  32'(pre_view),        32'h2F);
    chk("pre_foc_lit",   32'(foc_enable),      32'd0);
    chk("pre_fstep_lit", 32'(foc_step),        32'd5);
    flag_len("preset_pulse_len");
    repeat (5) put(1'b0, 8'h00);

    // Bad checksum, then corrected frame
    frame(8'hAA, 8'h04, 8'h8A, 8'h00); put(1'b0, 8'h00);
    @(negedge clk);
    chk("badsum_err_lit",  32'(frame_err),         32'd1);
    chk("badsum_flag_lit", 32'(flag_data_recieve), 32'd0);
    chk("badsum_pen_lit",  32'(pre_view_enable),   32'd1);
    @(negedge clk);
    chk("badsum_err_once", 32'(frame_err), 32'd0);
    frame(8'hAA, 8'h04, 8'h8A, 8'h24); put(1'b0, 8'h00);
    @(negedge clk);
    chk("iris_en_lit",   32'(Iris_enable), 32'd1);
    chk("iris_dir_lit",  32'(Iris_dir),    32'd1);
    chk("iris_step_lit", 32'(Iris_step),   32'd10);

    // Noise then unknown command
    put(1'b1, 8'h12); put(1'b1, 8'h34);
    frame(8'hAA, 8'h07, 8'h00, 8'hAD); put(1'b0, 8'h00);
    @(negedge clk);
    chk("unk_err_lit",  32'(frame_err),   32'd1);
    chk("unk_iris_lit", 32'(Iris_enable), 32'd1);

    // Timeout after a partial frame
    put(1'b1, 8'hAA); put(1'b1, 8'h05); put(1'b0, 8'h00);
    k = 0;
    for (int i = 0; i < 60000; i++) begin
      @(negedge clk);
      if (frame_err) break;
      k++;
    end
    chk("timeout_cycles", 32'(k), 32'(TIMEOUT));
    put(1'b1, 8'h01); put(1'b0, 8'h00);
    @(negedge clk);
    chk("late_byte_err", 32'(frame_err), 32'd0);
    frame(8'hAA, 8'h05, 8'h01, 8'hAE); put(1'b0, 8'h00);
    @(negedge clk);
    chk("defog_lit",    32'(touwu),       32'd1);
    chk("defog_ien_lit", 32'(Iris_enable), 32'd0);

    // Reset mid-pulse
    frame(8'hAA, 8'h01, 8'h01, 8'hAA);
    repeat (5) put(1'b0, 8'h00);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_flag",  32'(flag_data_recieve),   32'd0);
    chk("rstmid_zoom",  32'(video_switch_enable), 32'd0);
    chk("rstmid_touwu", 32'(touwu),               32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    frame(8'hAA, 8'h02, 8'h85, 8'h2D); put(1'b0, 8'h00);
    @(negedge clk);
    chk("post_rst_foc_en",   32'(foc_enable), 32'd1);
    chk("post_rst_foc_step", 32'(foc_step),   32'd5);

    // Randomized traffic: valid, corrupt, unknown, truncated frames and noise
    for (int f = 0; f < 400; f++) begin
      int kind;
      logic [7:0] c, p, s;
      kind = $urandom_range(0, 11);
      repeat ($urandom_range(0, 2)) put(1'b0, 8'h00);
      c = (kind < 8) ? 8'($urandom_range(1, 5)) : 8'($urandom_range(0, 255));
      p = 8'($urandom_range(0, 255));
      s = HDR ^ c ^ p;
      if (kind == 8) s = s ^ (8'h01 << $urandom_range(0, 7));
      if (kind == 11) begin
        put(1'b1, 8'($urandom_range(0, 255)));
      end else if (kind == 10) begin
        put(1'b1, HDR); put(1'b1, c);
      end else begin
        put(1'b1, HDR);
        if ($urandom_range(0, 4) == 0) put(1'b0, 8'h00);
        put(1'b1, c);
        put(1'b1, p);
        if ($urandom_range(0, 4) == 0) put(1'b0, 8'h00);
        put(1'b1, s);
      end
    end
    repeat (40) put(1'b0, 8'h00);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/host_cmd_parser.md
# host_cmd_parser

Byte-level parser for host command frames arriving on the camera-control UART receive path. It sits directly upstream of the lens/camera UART interface and converts validated host frames into the command levels and fields that interface consumes: zoom, focus, iris, preset view and defog. It also asserts the stretched `flag_data_recieve` strobe that launches the downstream transmit sequence. Corrupt, unknown or truncated frames are discarded and flagged on `frame_err`.

## Interface
- `HDR`, 8'hAA, frame header byte.
- `TIMEOUT`, 16'd50000, inter-byte timeout in clk cycles.
- `PULSE_LEN`, 8'd32, `flag_data_recieve` high time in clk cycles (≥16, so the /16 baud-domain consumer sees it).

Ports (reset rst, asynchronous, active-low; clock clk):
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-low reset
- `rx_data`  in  8  received byte, valid while `rx_valid` is high
- `rx_valid`  in  1  one-cycle byte strobe
- `flag_data_recieve`  out  1  new-command strobe, high for PULSE_LEN cycles
- `video_switch_enable`  out  1  zoom command active
- `big_to_small_flag`  out  1  zoom direction
- `foc_enable`  out  1  focus command active
- `foc_dir`  out  1  focus direction
- `foc_step`  out  4  focus step
- `Iris_enable`  out  1  iris command active
- `Iris_dir`  out  1  iris direction
- `Iris_step`  out  5  iris step
- `pre_view_enable`  out  1  preset command active
- `pre_view`  out  8  preset view code
- `touwu`  out  1  defog state
- `frame_err`  out  1  one-cycle pulse on a discarded frame

## Operation
- Frame: `HDR`, CMD, PARAM, SUM, where SUM = HDR ^ CMD ^ PARAM.
- FSM states: HUNT, GET_CMD, GET_PARAM, GET_SUM.
  - HUNT: on a byte equal to HDR, go to GET_CMD and load the running XOR with HDR. Any other byte is ignored without an error.
  - GET_CMD: latch CMD, XOR it in, go to GET_PARAM.
  - GET_PARAM: latch PARAM, XOR it in, go to GET_SUM.
  - GET_SUM: if the byte equals the running XOR and CMD is known, commit the frame. Otherwise pulse `frame_err`. Always return to HUNT.
- No resynchronisation inside a frame: HDR in a non-HUNT state is treated as ordinary data.
- Commit decode (all four `*_enable` outputs are rewritten on every commit; only the addressed one is 1):
  - CMD 01, zoom: `video_switch_enable`=1, `big_to_small_flag`=PARAM[0].
  - CMD 02, focus: `foc_enable`=1, `foc_dir`=PARAM[7], `foc_step`=PARAM[3:0].
  - CMD 03, preset: `pre_view_enable`=1, `pre_view`=PARAM.
  - CMD 04, iris: `Iris_enable`=1, `Iris_dir`=PARAM[7], `Iris_step`=PARAM[4:0].
  - CMD 05, defog: `touwu`=PARAM[0]. All enables go to 0.
  - Any other CMD is unknown. The frame is discarded with `frame_err`, and no outputs change.
- Direction/step fields not addressed by a commit hold their previous values. `pre_view` and `touwu` hold until rewritten.
- Command outputs stay as levels until the next valid commit.

## Timing
- Reset: FSM goes to HUNT, and every output, counter and internal register is 0.
- Latency: outputs update and `flag_data_recieve` rises on the same clk edge that samples a valid SUM byte with `rx_valid`.
- Pulse stretch: `flag_data_recieve` stays high for exactly PULSE_LEN cycles. A new commit during the pulse reloads the counter, so the pulse extends to PULSE_LEN after the latest commit.
- Command outputs are stable for the whole `flag_data_recieve` high time unless a newer commit occurs.
- Timeout counter:
  - Cleared on every `rx_valid`.
  - Counts only in GET_CMD, GET_PARAM and GET_SUM.
  - On reaching TIMEOUT it forces HUNT, pulses `frame_err` for one cycle and stops counting.
  - If `rx_valid` arrives on the timeout cycle, the byte wins and no error is raised.
- Back-to-back frames with zero idle bytes between them are accepted at the full `rx_valid` rate (one byte per cycle).
- An asynchronous reset mid-frame or mid-pulse takes effect immediately: outputs go to 0 and the FSM returns to HUNT.
- `frame_err` and `flag_data_recieve` never rise on the same edge.

## Test plan
- Zoom: AA 01 01 AA → `video_switch_enable`=1 and `big_to_small_flag`=1 on the SUM edge; `flag_data_recieve` high for exactly 32 cycles; other enables 0.
- Focus then preset: AA 02 85 2D, then AA 03 2F 86 → first `foc_enable`=1, `foc_dir`=1, `foc_step`=5. Then `pre_view_enable`=1, `pre_view`=8'h2F, `foc_enable`=0 with `foc_step` still 5; pulse stretched past the second commit.
- Bad checksum: AA 04 8A 00 → one `frame_err` pulse, no output change, no `flag_data_recieve`; the following AA 04 8A 24 is accepted with `Iris_dir`=1, `Iris_step`=10.
- Unknown command and noise: 12 34 AA 07 00 AD → leading bytes ignored, then one `frame_err` pulse and no commit.
- Timeout:
  - AA 05 then silence → after TIMEOUT cycles, one `frame_err` pulse and return to HUNT.
  - A late byte 01 arriving afterwards is ignored.
  - The next full frame AA 05 01 AE sets `touwu`=1.
- Reset mid-pulse: assert rst 5 cycles after a commit → all outputs 0 immediately; after release, a clean frame is parsed normally.
